// File: rtl/spi_xfer_scheduler_pkg.sv
// Shared definitions for the SPI transfer scheduler.
//   state_e        : controller states (IDLE=0, SETUP=1, SHIFT=2, DONE=3)
//   CPOL / CPHA    : SPI mode constants (mode 0: sample on rise, shift on fall)
//   WDOG_W_DEFAULT : default watchdog counter width
package spi_xfer_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int unsigned WDOG_W_DEFAULT = 13;

endpackage

// File: rtl/spi_xfer_scheduler_rr_arbiter.sv
// Round-robin arbiter for the SPI transfer scheduler.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request vector
//   last_gnt  : index of the requester that just finished, loaded on update
//   update    : strobe that moves the round-robin pointer to last_gnt
//   winner    : one-hot winner, first set request after the pointer (wrapping)
module spi_xfer_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
  input  logic                       update,
  output logic [NUM_REQ-1:0]         winner
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Pointer starts at the highest index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_W'(NUM_REQ - 1);
    end else if (update) begin
      ptr_q <= last_gnt;
    end
  end

  // Scan ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; the last candidate is ptr itself.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// SPI transfer scheduler: arbitrates NUM_REQ requesters round-robin onto one
// shared SCK generator and MOSI/MISO pair, runs one CPOL=0/CPHA=0 MSB-first
// transfer per grant and returns the received word with a done pulse.
//   clk_in, rst_in            : clock, asynchronous active-high reset
//   req_in / req_*_in         : per-requester request level, TX word, divider settings
//   gnt_out                   : one-hot grant, held for the whole transfer
//   done_out / err_out        : completion pulse to the winner / watchdog abort pulse
//   rx_data_out               : received word, updated on every done
//   gen_enable_out/_sppr/_spr : control of the external sck_generator
//   gen_sck_in, sck_out       : SCK from the generator and its pass-through
//   mosi_out, miso_in         : serial data
//   cs_n_out                  : active-low chip selects
module spi_xfer_scheduler
  import spi_xfer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WDOG_W  = WDOG_W_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
  input  logic [NUM_REQ*3-1:0]      req_sppr_in,
  input  logic [NUM_REQ*3-1:0]      req_spr_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [NUM_REQ-1:0]        done_out,
  output logic                      err_out,
  output logic [DATA_W-1:0]         rx_data_out,
  output logic                      gen_enable_out,
  output logic [2:0]                gen_sppr_out,
  output logic [2:0]                gen_spr_out,
  input  logic                      gen_sck_in,
  output logic                      sck_out,
  output logic                      mosi_out,
  input  logic                      miso_in,
  output logic [NUM_REQ-1:0]        cs_n_out
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  // Abort on the edge-free cycle that would take the counter to all ones.
  localparam logic [WDOG_W-1:0] WDOG_LAST = ~WDOG_W'(1);

  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  cs_n_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                err_q;
  logic                en_q;
  logic [2:0]          sppr_q;
  logic [2:0]          spr_q;
  logic                mosi_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic [DATA_W-1:0]   tx_sr_q;
  logic [DATA_W-1:0]   rx_sr_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                sck_q;
  logic [PTR_W-1:0]    cur_idx_q;

  logic [NUM_REQ-1:0]  win_oh;
  logic [PTR_W-1:0]    win_idx;
  logic [DATA_W-1:0]   win_data;
  logic [2:0]          win_sppr;
  logic [2:0]          win_spr;
  logic                sck_rise;
  logic                sck_fall;
  logic                sample_edge;
  logic                shift_edge;
  logic                arb_update;

  assign sck_rise = gen_sck_in & ~sck_q;
  assign sck_fall = ~gen_sck_in & sck_q;
  // Modes 1/2 sample on the falling edge; mode 0 (the one in use) samples on the rise.
  assign sample_edge = (CPOL ^ CPHA) ? sck_fall : sck_rise;
  assign shift_edge  = (CPOL ^ CPHA) ? sck_rise : sck_fall;

  // Pointer moves to the finished requester as the FSM leaves DONE.
  assign arb_update = (state_q == StDone);

  spi_xfer_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk_in),
    .rst      (rst_in),
    .req      (req_in),
    .last_gnt (cur_idx_q),
    .update   (arb_update),
    .winner   (win_oh)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    win_sppr = '0;
    win_spr  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_oh[i]) begin
        win_idx  = PTR_W'(i);
        win_data = req_data_in[i*DATA_W +: DATA_W];
        win_sppr = req_sppr_in[i*3 +: 3];
        win_spr  = req_spr_in[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      cs_n_q    <= '1;
      done_q    <= '0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      sppr_q    <= '0;
      spr_q     <= '0;
      mosi_q    <= 1'b0;
      rx_data_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      wdog_q    <= '0;
      sck_q     <= 1'b0;
      cur_idx_q <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      sck_q  <= gen_sck_in;
      unique case (state_q)
        StIdle: begin
          if (|req_in) begin
            gnt_q     <= win_oh;
            cs_n_q    <= ~win_oh;
            cur_idx_q <= win_idx;
            tx_sr_q   <= win_data;
            sppr_q    <= win_sppr;
            spr_q     <= win_spr;
            sck_q     <= 1'b0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          mosi_q    <= tx_sr_q[DATA_W-1];
          bit_cnt_q <= '0;
          wdog_q    <= '0;
          rx_sr_q   <= '0;
          en_q      <= 1'b1;
          state_q   <= StShift;
        end
        StShift: begin
          if (sample_edge) begin
            rx_sr_q   <= {rx_sr_q[DATA_W-2:0], miso_in};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
          if (shift_edge) begin
            if (bit_cnt_q == CNT_W'(DATA_W)) begin
              en_q      <= 1'b0;
              done_q    <= gnt_q;
              rx_data_q <= rx_sr_q;
              state_q   <= StDone;
            end else begin
              tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
              mosi_q  <= tx_sr_q[DATA_W-2];
            end
          end
          if (sample_edge || shift_edge) begin
            wdog_q <= '0;
          end else if (wdog_q == WDOG_LAST) begin
            // SCK stalled: abort with whatever bits have arrived.
            wdog_q    <= wdog_q + WDOG_W'(1);
            en_q      <= 1'b0;
            done_q    <= gnt_q;
            err_q     <= 1'b1;
            rx_data_q <= rx_sr_q;
            state_q   <= StDone;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        StDone: begin
          gnt_q   <= '0;
          cs_n_q  <= '1;
          mosi_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_out        = gnt_q;
  assign cs_n_out       = cs_n_q;
  assign done_out       = done_q;
  assign err_out        = err_q;
  assign gen_enable_out = en_q;
  assign gen_sppr_out   = sppr_q;
  assign gen_spr_out    = spr_q;
  assign mosi_out       = mosi_q;
  assign rx_data_out    = rx_data_q;
  assign sck_out        = gen_sck_in;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Self-checking bench for spi_xfer_scheduler with a behavioural SCK generator,
// SPI slave and round-robin reference model.
module tb_spi_xfer_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int WDOG_W  = 13;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_in = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data_in = '0;
  logic [NUM_REQ*3-1:0]      req_sppr_in = '0;
  logic [NUM_REQ*3-1:0]      req_spr_in = '0;
  logic [NUM_REQ-1:0]        gnt_out, done_out, cs_n_out;
  logic                      err_out, gen_enable_out, sck_out, mosi_out, miso_in;
  logic [DATA_W-1:0]         rx_data_out;
  logic [2:0]                gen_sppr_out, gen_spr_out;
  logic                      gen_sck = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_scheduler #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .WDOG_W  (WDOG_W)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .req_in         (req_in),
    .req_data_in    (req_data_in),
    .req_sppr_in    (req_sppr_in),
    .req_spr_in     (req_spr_in),
    .gnt_out        (gnt_out),
    .done_out       (done_out),
    .err_out        (err_out),
    .rx_data_out    (rx_data_out),
    .gen_enable_out (gen_enable_out),
    .gen_sppr_out   (gen_sppr_out),
    .gen_spr_out    (gen_spr_out),
    .gen_sck_in     (gen_sck),
    .sck_out        (sck_out),
    .mosi_out       (mosi_out),
    .miso_in        (miso_in),
    .cs_n_out       (cs_n_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- SCK generator + SPI slave model ----------------
  logic              loopback = 1'b0;
  logic              tie0 = 1'b0;
  logic [DATA_W-1:0] slave_word = '0;
  logic [DATA_W-1:0] slave_sr = '0;
  logic [DATA_W-1:0] mosi_cap = '0;
  logic              miso_bit = 1'b0;
  int                half_cnt = 0;
  int                rise_cnt = 0;

  assign miso_in = loopback ? mosi_out : miso_bit;

  always @(negedge clk) begin
    int half;
    half = (int'(gen_sppr_out) + 1) * (int'(gen_spr_out) + 1);
    if (!gen_enable_out || tie0) begin
      gen_sck  = 1'b0;
      half_cnt = 0;
      if (!gen_enable_out) begin
        slave_sr = slave_word;
        rise_cnt = 0;
      end
    end else begin
      half_cnt++;
      if (half_cnt >= half) begin
        half_cnt = 0;
        if (!gen_sck) begin
          gen_sck  = 1'b1;
          rise_cnt++;
          mosi_cap = {mosi_cap[DATA_W-2:0], mosi_out};
        end else begin
          gen_sck  = 1'b0;
          slave_sr = {slave_sr[DATA_W-2:0], 1'b0};
        end
      end
    end
    miso_bit = slave_sr[DATA_W-1];
  end

  // ---------------- protocol monitors ----------------
  logic       bad_multi = 1'b0, bad_cs = 1'b0, bad_done = 1'b0, bad_set = 1'b0;
  logic       bad_sck = 1'b0;
  logic       prev_en = 1'b0;
  logic [5:0] prev_set = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(gnt_out) > 1) bad_multi = 1'b1;
      if (cs_n_out !== ~gnt_out) bad_cs = 1'b1;
      if (done_out != '0 && done_out != gnt_out) bad_done = 1'b1;
      if (gen_enable_out && prev_en && ({gen_sppr_out, gen_spr_out} != prev_set)) bad_set = 1'b1;
      if (sck_out !== gen_sck) bad_sck = 1'b1;
    end
    prev_en  = gen_enable_out;
    prev_set = {gen_sppr_out, gen_spr_out};
  end

  // ---------------- reference model ----------------
  int                last = NUM_REQ - 1;
  logic [DATA_W-1:0] m_data [NUM_REQ];
  logic [2:0]        m_sppr [NUM_REQ];
  logic [2:0]        m_spr  [NUM_REQ];

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int from);
    int c;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (from + k) % NUM_REQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [DATA_W-1:0] d, input logic [2:0] sp,
                         input logic [2:0] s);
    m_data[i] = d;
    m_sppr[i] = sp;
    m_spr[i]  = s;
    req_data_in[i*DATA_W +: DATA_W] = d;
    req_sppr_in[i*3 +: 3] = sp;
    req_spr_in[i*3 +: 3]  = s;
    req_in[i] = 1'b1;
  endtask

  // One transfer: waits for the grant, checks it against the model, waits for done.
  task automatic xfer(input bit hold, input int exp_gap, output int w);
    int                 cyc;
    logic [NUM_REQ-1:0] exp_g, exp_cs;
    logic [DATA_W-1:0]  tx, exp_rx;
    w = rr_pick(req_in, last);
    exp_g = '0;
    if (w >= 0) exp_g[w] = 1'b1;
    exp_cs = ~exp_g;
    slave_word = DATA_W'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt_out == '0 && cyc < 300);
    check("grant", 32'(gnt_out), 32'(exp_g));
    if (exp_gap > 0) check("grant_latency", cyc, exp_gap);
    if (w < 0) return;
    check("cs_at_grant", 32'(cs_n_out), 32'(exp_cs));
    check("sppr", 32'(gen_sppr_out), 32'(m_sppr[w]));
    check("spr", 32'(gen_spr_out), 32'(m_spr[w]));
    check("en_at_grant", 32'(gen_enable_out), 0);
    tx = m_data[w];
    exp_rx = loopback ? tx : slave_word;
    if (!hold) req_in[w] = 1'b0;
    @(negedge clk);
    check("en_after_grant", 32'(gen_enable_out), 1);
    cyc = 0;
    while (done_out == '0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("done", 32'(done_out), 32'(exp_g));
    check("err", 32'(err_out), 0);
    check("rx_data", 32'(rx_data_out), 32'(exp_rx));
    check("mosi_stream", 32'(mosi_cap), 32'(tx));
    check("cs_at_done", 32'(cs_n_out), 32'(exp_cs));
    last = w;
  endtask

  int                 w, cyc, en_cyc;
  int                 order [5] = '{0, 1, 2, 3, 0};
  logic [NUM_REQ-1:0] all_ones;

  initial begin
    all_ones = '1;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt_out), 0);
    check("rst_cs", 32'(cs_n_out), 32'(all_ones));
    check("rst_en", 32'(gen_enable_out), 0);
    check("rst_rx", 32'(rx_data_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // Contention: all four requesting continuously.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, DATA_W'($urandom), 3'($urandom_range(0, 3)),
                                               3'($urandom_range(0, 3)));
    for (int k = 0; k < 5; k++) begin
      xfer(1'b1, (k == 0) ? 1 : 2, w);
      check("rr_order", w, order[k]);
    end
    req_in = '0;
    repeat (2) @(negedge clk);

    // Single request, loopback, directed data.
    loopback = 1'b1;
    set_req(0, 8'hA5, 3'd0, 3'd0);
    xfer(1'b0, 1, w);
    loopback = 1'b0;
    repeat (2) @(negedge clk);

    // Settings routing.
    set_req(2, DATA_W'($urandom), 3'd3, 3'd1);
    xfer(1'b0, 1, w);
    repeat (2) @(negedge clk);

    // Request dropped right after grant still completes.
    set_req(1, DATA_W'($urandom), 3'd1, 3'd0);
    xfer(1'b0, 1, w);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-transfer.
    set_req(0, DATA_W'($urandom), 3'd1, 3'd1);
    cyc = 0;
    while (rise_cnt < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_4th_rise", 32'(rise_cnt >= 4), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt_out), 0);
    check("mid_rst_done", 32'(done_out), 0);
    check("mid_rst_cs", 32'(cs_n_out), 32'(all_ones));
    check("mid_rst_en", 32'(gen_enable_out), 0);
    check("mid_rst_mosi", 32'(mosi_out), 0);
    check("mid_rst_set", 32'({gen_sppr_out, gen_spr_out}), 0);
    check("mid_rst_rx", 32'(rx_data_out), 0);
    @(negedge clk);
    check("rst_no_done", 32'(done_out), 0);
    rst  = 1'b0;
    last = NUM_REQ - 1;
    set_req(1, DATA_W'($urandom), 3'd0, 3'd1);
    xfer(1'b0, 1, w);
    check("post_rst_first", w, 0);
    xfer(1'b0, 0, w);

    // Randomized traffic against the model.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_in[i] && $urandom_range(0, 1) == 1)
          set_req(i, DATA_W'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
      end
      if (req_in == '0)
        set_req(int'($urandom_range(0, NUM_REQ - 1)), DATA_W'($urandom), 3'd0, 3'd0);
      xfer(1'b0, 0, w);
    end
    for (int k = 0; k < NUM_REQ && req_in != '0; k++) xfer(1'b0, 0, w);
    repeat (2) @(negedge clk);

    // Watchdog: SCK held low during SHIFT.
    tie0 = 1'b1;
    set_req(3, DATA_W'($urandom), 3'd0, 3'd0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt_out == '0 && cyc < 50);
    check("wd_grant", 32'(gnt_out), 32'h8);
    req_in[3] = 1'b0;
    cyc = 0;
    en_cyc = 0;
    while (done_out == '0 && cyc < 9000) begin
      @(negedge clk);
      cyc++;
      if (gen_enable_out) en_cyc++;
    end
    check("wd_done", 32'(done_out), 32'h8);
    check("wd_err", 32'(err_out), 1);
    check("wd_shift_cycles", en_cyc, (1 << WDOG_W) - 1);
    @(negedge clk);
    check("wd_err_pulse", 32'(err_out), 0);
    check("wd_done_pulse", 32'(done_out), 0);
    check("wd_idle_gnt", 32'(gnt_out), 0);
    tie0 = 1'b0;

    check("one_hot_grant", 32'(bad_multi), 0);
    check("cs_tracks_grant", 32'(bad_cs), 0);
    check("done_to_winner", 32'(bad_done), 0);
    check("settings_stable", 32'(bad_set), 0);
    check("sck_passthrough", 32'(bad_sck), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
